// File: rtl/nn_pkg.sv
// Shared definitions for the small NN compute datapath: X-buffer FSM
// encoding, activation bank numbers and layer lengths used by both the
// activation buffer and the compute engine.
package nn_pkg;

    // Activation buffer FSM states.
    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Bank numbers on x_sel. Bank 0 holds the input image and belongs to
    // the host preload; the engine may only write the hidden-layer banks.
    localparam logic [1:0] BANK_IN = 2'd0;
    localparam logic [1:0] BANK_H1 = 2'd1;
    localparam logic [1:0] BANK_H2 = 2'd2;
    localparam logic [1:0] BANK_H3 = 2'd3;

    // Layer lengths shared with the compute engine.
    localparam int NN_X1_LEN = 784;
    localparam int NN_H1_LEN = 256;
    localparam int NN_H2_LEN = 256;
    localparam int NN_H3_LEN = 128;

    // True when a bank number may be written by the compute engine.
    function automatic logic bank_is_writable(input logic [1:0] sel);
        return (sel != BANK_IN);
    endfunction

endpackage

// File: rtl/x_bank.sv
// One 1-bit-wide activation bank: asynchronous read, synchronous write.
// Contents are deliberately not reset.
module x_bank #(
    parameter int ADDR_LEN = 10
) (
    input  logic                clk,
    input  logic                i_we,
    input  logic [ADDR_LEN-1:0] i_waddr,
    input  logic                i_wdata,
    input  logic [ADDR_LEN-1:0] i_raddr,
    output logic                o_rdata
);

    localparam int DEPTH = 1 << ADDR_LEN;

    logic r_mem [DEPTH];

    // Write port: one bit per cycle when enabled.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/x_act_buffer.sv
// Responder side of the X-memory interface. Preloads bank 0 from a host
// bit-stream, enables the compute engine, serves its asynchronous reads
// and edge-strobed single-bit writes, then returns to preload on finish.
//
// Preload handshake: a beat transfers on a rising clk edge where
// ld_valid && ld_ready are both high; ld_data/ld_last are sampled only
// then. ld_ready is high exactly while the FSM is in LOAD, and ld_valid
// outside LOAD never consumes a beat.
module x_act_buffer
    import nn_pkg::*;
#(
    parameter int X_ADDR_LEN = 10,
    parameter int X_SEL_LEN  = 2,
    parameter int X1_LEN     = 784
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ld_valid,
    input  logic                  ld_data,
    input  logic                  ld_last,
    output logic                  ld_ready,
    output logic                  en,
    input  logic                  compute_finish,
    input  logic [X_ADDR_LEN-1:0] x_addr,
    input  logic [X_SEL_LEN-1:0]  x_sel,
    input  logic                  x_wq,
    input  logic                  wx_write,
    output logic                  x_data,
    output logic                  wr_err,
    output state_t                dbg_state,
    output logic [X_ADDR_LEN-1:0] dbg_ld_ptr
);

    localparam int                  NUM_BANKS = 1 << X_SEL_LEN;
    localparam logic [X_ADDR_LEN-1:0] LD_LAST_PTR = X_ADDR_LEN'(X1_LEN - 1);

    state_t                r_state;
    logic [X_ADDR_LEN-1:0] r_ld_ptr;
    logic                  r_x_wq_d;
    logic                  r_en;
    logic                  r_ld_ready;
    logic                  r_wr_err;

    logic                  w_ld_accept;
    logic                  w_ld_done;
    logic                  w_wq_rise;
    logic                  w_run_strobe;
    logic                  w_sel_writable;
    logic                  w_bad_strobe;
    logic                  w_bad_ld;
    logic                  w_rd_bit;

    logic                  w_we    [NUM_BANKS];
    logic [X_ADDR_LEN-1:0] w_waddr [NUM_BANKS];
    logic                  w_wdata [NUM_BANKS];
    logic                  w_rdata [NUM_BANKS];

    assign w_ld_accept    = (r_state == ST_LOAD) && ld_valid && r_ld_ready;
    assign w_ld_done      = w_ld_accept && (ld_last || (r_ld_ptr == LD_LAST_PTR));
    assign w_wq_rise      = x_wq && !r_x_wq_d;
    assign w_run_strobe   = (r_state == ST_RUN) && w_wq_rise;
    assign w_sel_writable = (x_sel != X_SEL_LEN'(BANK_IN));
    assign w_bad_strobe   = w_run_strobe && !w_sel_writable;
    assign w_bad_ld       = ld_valid && ((r_state == ST_START) || (r_state == ST_RUN));

    // FSM, preload pointer, strobe history, enable/ready and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_LOAD;
            r_ld_ptr   <= '0;
            r_x_wq_d   <= 1'b0;
            r_en       <= 1'b0;
            r_ld_ready <= 1'b1;
            r_wr_err   <= 1'b0;
        end else begin
            r_x_wq_d <= x_wq;
            if (w_bad_strobe || w_bad_ld) begin
                r_wr_err <= 1'b1;
            end
            case (r_state)
                ST_LOAD: begin
                    if (w_ld_done) begin
                        r_state    <= ST_START;
                        r_ld_ptr   <= '0;
                        r_ld_ready <= 1'b0;
                    end else if (w_ld_accept) begin
                        r_ld_ptr <= r_ld_ptr + 1'b1;
                    end
                end
                ST_START: begin
                    r_state <= ST_RUN;
                    r_en    <= 1'b1;
                end
                ST_RUN: begin
                    if (compute_finish) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    r_state    <= ST_LOAD;
                    r_en       <= 1'b0;
                    r_x_wq_d   <= 1'b0;
                    r_ld_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

    // Write decode: bank 0 is fed only by the preload stream, the
    // hidden-layer banks only by rising-edge engine strobes in RUN.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (b == 0) begin
                w_we[b]    = w_ld_accept;
                w_waddr[b] = r_ld_ptr;
                w_wdata[b] = ld_data;
            end else begin
                w_we[b]    = w_run_strobe && (x_sel == X_SEL_LEN'(b));
                w_waddr[b] = x_addr;
                w_wdata[b] = wx_write;
            end
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        x_bank #(
            .ADDR_LEN (X_ADDR_LEN)
        ) u_bank (
            .clk     (clk),
            .i_we    (w_we[g]),
            .i_waddr (w_waddr[g]),
            .i_wdata (w_wdata[g]),
            .i_raddr (x_addr),
            .o_rdata (w_rdata[g])
        );
    end

    // Read mux; the engine sees nothing but zeros outside RUN.
    always_comb begin
        w_rd_bit = w_rdata[x_sel];
        if (r_state != ST_RUN) begin
            w_rd_bit = 1'b0;
        end
    end

    assign x_data     = w_rd_bit;
    assign en         = r_en;
    assign ld_ready   = r_ld_ready;
    assign wr_err     = r_wr_err;
    assign dbg_state  = r_state;
    assign dbg_ld_ptr = r_ld_ptr;

endmodule

// File: tb/tb_x_act_buffer.sv
// Directed bench for x_act_buffer: a table of read vectors with
// hand-computed expected bits, plus hand-written multi-cycle sequences for
// preload, strobed writes, errors, finish/reload and mid-RUN reset.
module tb_x_act_buffer;
  import nn_pkg::*;

  localparam int AW = 10;
  localparam int SW = 2;

  logic          clk;
  logic          rst_n;
  logic          ld_valid;
  logic          ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic          en;
  logic          compute_finish;
  logic [AW-1:0] x_addr;
  logic [SW-1:0] x_sel;
  logic          x_wq;
  logic          wx_write;
  logic          x_data;
  logic          wr_err;
  state_t        dbg_state;
  logic [AW-1:0] dbg_ld_ptr;

  int n_checks;
  int n_errors;

  typedef struct {
    int            phase;
    logic [SW-1:0] sel;
    logic [AW-1:0] addr;
    logic          exp;
  } rd_vec_t;

  rd_vec_t rv[20];

  x_act_buffer #(
    .X_ADDR_LEN (AW),
    .X_SEL_LEN  (SW),
    .X1_LEN     (784)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ld_valid       (ld_valid),
    .ld_data        (ld_data),
    .ld_last        (ld_last),
    .ld_ready       (ld_ready),
    .en             (en),
    .compute_finish (compute_finish),
    .x_addr         (x_addr),
    .x_sel          (x_sel),
    .x_wq           (x_wq),
    .wx_write       (wx_write),
    .x_data         (x_data),
    .wr_err         (wr_err),
    .dbg_state      (dbg_state),
    .dbg_ld_ptr     (dbg_ld_ptr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // driver tasks
  task automatic beat(input logic d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic strobe(input logic [SW-1:0] sel, input logic [AW-1:0] addr,
                        input logic d, input int len);
    x_sel    = sel;
    x_addr   = addr;
    wx_write = d;
    x_wq     = 1'b1;
    for (int k = 0; k < len; k++) tick();
    x_wq = 1'b0;
    tick();
  endtask

  task automatic run_reads(input int ph);
    for (int i = 0; i < 20; i++) begin
      if (rv[i].phase == ph) begin
        x_sel  = rv[i].sel;
        x_addr = rv[i].addr;
        #1;
        chk($sformatf("rd_p%0d_s%0d_a%0d", ph, rv[i].sel, rv[i].addr),
            32'(x_data), 32'(rv[i].exp));
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    // phase 1: first image 1,0,1,0,...
    rv[0]  = '{1, 2'd0, 10'd0,    1'b1};
    rv[1]  = '{1, 2'd0, 10'd1,    1'b0};
    rv[2]  = '{1, 2'd0, 10'd2,    1'b1};
    rv[3]  = '{1, 2'd0, 10'd3,    1'b0};
    rv[4]  = '{1, 2'd0, 10'd782,  1'b1};
    rv[5]  = '{1, 2'd0, 10'd783,  1'b0};
    // phase 2: after engine writes
    rv[6]  = '{2, 2'd2, 10'd5,    1'b1};
    rv[7]  = '{2, 2'd2, 10'd6,    1'b0};
    rv[8]  = '{2, 2'd3, 10'd1023, 1'b1};
    rv[9]  = '{2, 2'd1, 10'd17,   1'b1};
    // phase 3: after reload with 0,1,0,1,...; hidden banks retained
    rv[10] = '{3, 2'd0, 10'd0,    1'b0};
    rv[11] = '{3, 2'd0, 10'd1,    1'b1};
    rv[12] = '{3, 2'd2, 10'd5,    1'b1};
    rv[13] = '{3, 2'd3, 10'd1023, 1'b1};
    // phase 4: early-last image 1,1,0,1,0
    rv[14] = '{4, 2'd0, 10'd0,    1'b1};
    rv[15] = '{4, 2'd0, 10'd1,    1'b1};
    rv[16] = '{4, 2'd0, 10'd2,    1'b0};
    rv[17] = '{4, 2'd0, 10'd3,    1'b1};
    rv[18] = '{4, 2'd0, 10'd4,    1'b0};
    rv[19] = '{4, 2'd1, 10'd17,   1'b1};

    rst_n = 1'b0; ld_valid = 1'b0; ld_data = 1'b0; ld_last = 1'b0;
    compute_finish = 1'b0; x_addr = '0; x_sel = '0; x_wq = 1'b0; wx_write = 1'b0;
    #12;
    chk("rst_en", 32'(en), 32'd0);
    chk("rst_ld_ready", 32'(ld_ready), 32'd1);
    chk("rst_x_data", 32'(x_data), 32'd0);
    chk("rst_wr_err", 32'(wr_err), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_LOAD));
    chk("rst_ptr", 32'(dbg_ld_ptr), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // full preload, ld_last on beat 784
    for (int i = 0; i < 784; i++) begin
      if (i == 100) chk("pre_ptr100", 32'(dbg_ld_ptr), 32'd100);
      beat(~i[0], i == 783);
    end
    chk("pre_ld_ready_fall", 32'(ld_ready), 32'd0);
    chk("pre_state_start", 32'(dbg_state), 32'(ST_START));
    chk("pre_en_edge1", 32'(en), 32'd0);
    chk("pre_ptr_zero", 32'(dbg_ld_ptr), 32'd0);
    chk("start_x_data", 32'(x_data), 32'd0);
    tick();
    chk("pre_en_edge2", 32'(en), 32'd1);
    chk("pre_state_run", 32'(dbg_state), 32'(ST_RUN));
    run_reads(1);

    // write strobe: first write a known 0, then 1 with a 3-cycle strobe
    strobe(2'd1, 10'd17, 1'b0, 1);
    #1;
    chk("wr_init0", 32'(x_data), 32'd0);
    wx_write = 1'b1;
    x_wq     = 1'b1;
    #1;
    chk("wr_old_value", 32'(x_data), 32'd0);
    tick();
    chk("wr_new_value", 32'(x_data), 32'd1);
    wx_write = 1'b0;
    tick();
    tick();
    chk("wr_one_per_pulse", 32'(x_data), 32'd1);
    x_wq = 1'b0;
    tick();
    strobe(2'd2, 10'd5, 1'b1, 1);
    strobe(2'd2, 10'd6, 1'b0, 2);
    strobe(2'd3, 10'd1023, 1'b1, 1);
    chk("wr_err_clean", 32'(wr_err), 32'd0);
    run_reads(2);

    // illegal strobe to bank 0
    strobe(2'd0, 10'd0, 1'b0, 1);
    chk("ill_wr_err", 32'(wr_err), 32'd1);
    x_sel = 2'd0; x_addr = 10'd0; #1;
    chk("ill_bank0_kept", 32'(x_data), 32'd1);
    tick(); tick();
    chk("ill_wr_err_sticky", 32'(wr_err), 32'd1);

    // finish and reload (pointer-terminated, no ld_last)
    compute_finish = 1'b1;
    tick();
    compute_finish = 1'b0;
    chk("fin_edge1_en", 32'(en), 32'd1);
    chk("fin_state_drain", 32'(dbg_state), 32'(ST_DRAIN));
    tick();
    chk("fin_edge2_en", 32'(en), 32'd0);
    chk("fin_ld_ready", 32'(ld_ready), 32'd1);
    chk("fin_state_load", 32'(dbg_state), 32'(ST_LOAD));
    for (int i = 0; i < 784; i++) beat(i[0], 1'b0);
    chk("rel_state_start", 32'(dbg_state), 32'(ST_START));
    chk("rel_ptr_zero", 32'(dbg_ld_ptr), 32'd0);
    tick();
    chk("rel_en", 32'(en), 32'd1);
    run_reads(3);
    chk("rel_wr_err_sticky", 32'(wr_err), 32'd1);

    // reset mid-RUN, asserted between edges
    x_sel = 2'd2; x_addr = 10'd5;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_en", 32'(en), 32'd0);
    chk("mid_rst_x_data", 32'(x_data), 32'd0);
    chk("mid_rst_wr_err", 32'(wr_err), 32'd0);
    chk("mid_rst_state", 32'(dbg_state), 32'(ST_LOAD));
    chk("mid_rst_ptr", 32'(dbg_ld_ptr), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_ld_ready", 32'(ld_ready), 32'd1);

    // strobe outside RUN must not write bank 1
    strobe(2'd1, 10'd17, 1'b0, 1);

    // early ld_last on beat 5, with an idle gap
    beat(1'b1, 1'b0);
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b0);
    tick();
    chk("early_ptr3", 32'(dbg_ld_ptr), 32'd3);
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b1);
    chk("early_state_start", 32'(dbg_state), 32'(ST_START));
    chk("early_ptr_zero", 32'(dbg_ld_ptr), 32'd0);
    chk("early_ld_ready", 32'(ld_ready), 32'd0);
    tick();
    chk("early_en", 32'(en), 32'd1);
    run_reads(4);

    // ld_valid during RUN
    ld_valid = 1'b1;
    ld_data  = 1'b1;
    tick();
    ld_valid = 1'b0;
    chk("ldv_run_wr_err", 32'(wr_err), 32'd1);
    chk("ldv_run_ld_ready", 32'(ld_ready), 32'd0);
    chk("ldv_run_ptr", 32'(dbg_ld_ptr), 32'd0);
    chk("ldv_run_state", 32'(dbg_state), 32'(ST_RUN));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
